// File: rtl/ps2_kd_pkg.sv
// Shared constants and state types for the PS/2 keyboard front end.
package ps2_kd_pkg;

   localparam int NUM_KEYS = 6;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_START  = 8'h1D;
   localparam logic [7:0] SC_DOWN   = 8'h1B;
   localparam logic [7:0] SC_LEFT   = 8'h1C;
   localparam logic [7:0] SC_RIGHT  = 8'h23;
   localparam logic [7:0] SC_ROTATE = 8'h29;
   localparam logic [7:0] SC_DROP   = 8'h5A;

   localparam int KEY_START  = 0;
   localparam int KEY_DOWN   = 1;
   localparam int KEY_LEFT   = 2;
   localparam int KEY_RIGHT  = 3;
   localparam int KEY_ROTATE = 4;
   localparam int KEY_DROP   = 5;

   typedef enum logic {IDLE, RECV} rx_state_t;
   typedef enum logic [1:0] {NORMAL, BRK, EXT, EXT_BRK} dec_state_t;

   // One-hot key vector for a scan code; all zeros for codes the game ignores.
   function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
      key_onehot = '0;
      case (code)
         SC_START:  key_onehot[KEY_START]  = 1'b1;
         SC_DOWN:   key_onehot[KEY_DOWN]   = 1'b1;
         SC_LEFT:   key_onehot[KEY_LEFT]   = 1'b1;
         SC_RIGHT:  key_onehot[KEY_RIGHT]  = 1'b1;
         SC_ROTATE: key_onehot[KEY_ROTATE] = 1'b1;
         SC_DROP:   key_onehot[KEY_DROP]   = 1'b1;
         default:   key_onehot = '0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizer, clock filter, 11-bit
// deserializer with start/parity/stop checking and an inactivity timeout.
module ps2_rx_frame
   import ps2_kd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       rd_data_valid,
   output logic [7:0] rd_data_payload,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_s1, clk_s2, data_s1, data_s2;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fe;
   rx_state_t     state;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   // The filtered clock only follows after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         fe       <= 1'b0;
      end else begin
         fe <= 1'b0;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
            fe       <= ~clk_s2;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // Data and parity shift in from the top so the payload lands LSB-aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         bit_cnt         <= '0;
         shift           <= '0;
         to_cnt          <= '0;
         rd_data_valid   <= 1'b0;
         rd_data_payload <= '0;
         frame_err       <= 1'b0;
      end else begin
         rd_data_valid <= 1'b0;
         frame_err     <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (fe) begin
                  if (!data_s2) begin
                     state   <= RECV;
                     bit_cnt <= 4'd1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (fe) begin
                  to_cnt <= '0;
                  if (bit_cnt == 4'd10) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     if (data_s2 && (^shift)) begin
                        rd_data_valid   <= 1'b1;
                        rd_data_payload <= shift[7:0];
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     shift   <= {data_s2, shift[8:1]};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  to_cnt    <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for tetris_core: frame receiver plus F0/E0 prefix
// decoder mapping six scan codes to make pulses and held levels.
module ps2_key_decoder
   import ps2_kd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic                rd_data_valid,
   output logic [7:0]          rd_data_payload,
   output logic [NUM_KEYS-1:0] keys_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic                frame_err
);

   dec_state_t          dec_state;
   logic [NUM_KEYS-1:0] code_keys;

   ps2_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk             (clk),
      .reset           (reset),
      .ps2_clk         (ps2_clk),
      .ps2_data        (ps2_data),
      .rd_data_valid   (rd_data_valid),
      .rd_data_payload (rd_data_payload),
      .frame_err       (frame_err)
   );

   assign code_keys = key_onehot(rd_data_payload);

   // Extended-prefixed codes are swallowed so keypad keys never alias game keys.
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_state  <= NORMAL;
         keys_valid <= '0;
         key_held   <= '0;
      end else begin
         keys_valid <= '0;
         if (rd_data_valid) begin
            case (dec_state)
               NORMAL: begin
                  if (rd_data_payload == SC_BREAK) begin
                     dec_state <= BRK;
                  end else if (rd_data_payload == SC_EXT) begin
                     dec_state <= EXT;
                  end else begin
                     keys_valid <= code_keys;
                     key_held   <= key_held | code_keys;
                  end
               end
               BRK: begin
                  key_held  <= key_held & ~code_keys;
                  dec_state <= NORMAL;
               end
               EXT: begin
                  if (rd_data_payload == SC_BREAK) begin
                     dec_state <= EXT_BRK;
                  end else begin
                     dec_state <= NORMAL;
                  end
               end
               EXT_BRK: begin
                  dec_state <= NORMAL;
               end
            endcase
         end
      end
   end

endmodule
